epp_update_sched: RTL and testbench

Update scheduler for the EPD panel timing engine. It accepts one display-update request at a time and sequences panel power-up, the clean phase (solid black frames, then solid white frames), the grayscale waveform phase and power-down. For each frame it hands the timing engine a frame-start pulse plus that frame's drive code and LUT index, then waits for the engine's frame-done pulse. It sits between the host/button logic and the line/frame timing generator, all in the `glb_clk` domain.

---
 rtl/epp_update_sched.sv | 178 +++++++++++++++++
 tb/tb_epp_update_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/epp_update_sched.sv
// EPD update scheduler: power-up, clean (black/white), gray and fill frame sequencing, power-down.
// Optional abort input enabled by defining EPP_SCHED_ABORT_EN.
module epp_update_sched #(
  parameter int unsigned CLEAN_FRAMES = 48,
  parameter int unsigned GRAY_FRAMES  = 20,
  parameter int unsigned FILL_FRAMES  = 24,
  parameter int unsigned PWR_TIMEOUT  = 1023,
  parameter int unsigned PWR_DN_HOLD  = 255
) (
  input  logic       glb_clk,
  input  logic       glb_rst,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  output logic       pwr_en,
  input  logic       pwr_good,
  output logic       frm_start,
  input  logic       frm_done,
  output logic [1:0] frm_drive,
  output logic [4:0] frm_gray_idx,
  output logic       busy,
  output logic       upd_done,
  output logic       err
`ifdef EPP_SCHED_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int unsigned TMR_MAX = (PWR_TIMEOUT > PWR_DN_HOLD) ? PWR_TIMEOUT : PWR_DN_HOLD;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_PWR_UP, S_START, S_WAIT, S_PWR_DN, S_ERR} state_t;
  typedef enum logic [1:0] {PH_CLEAN, PH_GRAY, PH_FILL} phase_t;

  state_t        state, nxt;
  phase_t        phase, nxt_phase;
  logic [5:0]    frm_cnt, nxt_cnt;
  logic [TW-1:0] tmr, nxt_tmr;
  logic [1:0]    mode_q, nxt_mode;
  logic          abort_q, nxt_abort;
  logic          done_pulse;
  logic          abort_in;
  logic          phase_last;

`ifdef EPP_SCHED_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  function automatic logic [5:0] phase_len(phase_t p);
    case (p)
      PH_CLEAN: phase_len = 6'(CLEAN_FRAMES);
      PH_GRAY:  phase_len = 6'(GRAY_FRAMES);
      default:  phase_len = 6'(FILL_FRAMES);
    endcase
  endfunction

  function automatic logic [1:0] drive_of(phase_t p, logic [5:0] k);
    case (p)
      PH_CLEAN: drive_of = (k < 6'(CLEAN_FRAMES / 2)) ? 2'b01 : 2'b10;
      PH_GRAY:  drive_of = 2'b00;
      default:  drive_of = 2'b01;
    endcase
  endfunction

  assign phase_last = (frm_cnt == phase_len(phase) - 6'd1);

  always_comb begin
    nxt        = state;
    nxt_phase  = phase;
    nxt_cnt    = frm_cnt;
    nxt_tmr    = tmr;
    nxt_mode   = mode_q;
    nxt_abort  = abort_q;
    done_pulse = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          nxt       = S_PWR_UP;
          nxt_mode  = req_mode;
          nxt_tmr   = '0;
          nxt_cnt   = '0;
          nxt_abort = 1'b0;
          case (req_mode)
            2'd2:    nxt_phase = PH_GRAY;
            2'd3:    nxt_phase = PH_FILL;
            default: nxt_phase = PH_CLEAN;
          endcase
        end
      end
      S_PWR_UP: begin
        if (abort_in) begin
          nxt     = S_PWR_DN;
          nxt_tmr = '0;
        end else if (pwr_good) begin
          nxt = S_START;
        end else if (tmr == TW'(PWR_TIMEOUT)) begin
          nxt = S_ERR;
        end else begin
          nxt_tmr = tmr + TW'(1);
        end
      end
      S_START: begin
        if (abort_in) nxt_abort = 1'b1;
        nxt = pwr_good ? S_WAIT : S_ERR;
      end
      S_WAIT: begin
        if (abort_in) nxt_abort = 1'b1;
        if (!pwr_good) begin
          nxt = S_ERR;
        end else if (frm_done) begin
          if (abort_q || abort_in) begin
            nxt     = S_PWR_DN;
            nxt_tmr = '0;
          end else if (!phase_last) begin
            nxt     = S_START;
            nxt_cnt = frm_cnt + 6'd1;
          end else if (phase == PH_CLEAN && mode_q == 2'd0) begin
            nxt       = S_START;
            nxt_phase = PH_GRAY;
            nxt_cnt   = '0;
          end else begin
            nxt     = S_PWR_DN;
            nxt_tmr = '0;
          end
        end
      end
      S_PWR_DN: begin
        // upd_done lands one cycle before IDLE so req_ready follows it
        nxt_tmr = tmr + TW'(1);
        if (tmr == TW'(PWR_DN_HOLD - 1)) done_pulse = 1'b1;
        if (tmr == TW'(PWR_DN_HOLD))     nxt = S_IDLE;
      end
      S_ERR:   nxt = S_ERR;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      state        <= S_IDLE;
      phase        <= PH_CLEAN;
      frm_cnt      <= '0;
      tmr          <= '0;
      mode_q       <= '0;
      abort_q      <= 1'b0;
      req_ready    <= 1'b1;
      pwr_en       <= 1'b0;
      frm_start    <= 1'b0;
      frm_drive    <= '0;
      frm_gray_idx <= '0;
      busy         <= 1'b0;
      upd_done     <= 1'b0;
      err          <= 1'b0;
    end else begin
      state     <= nxt;
      phase     <= nxt_phase;
      frm_cnt   <= nxt_cnt;
      tmr       <= nxt_tmr;
      mode_q    <= nxt_mode;
      abort_q   <= nxt_abort;
      // outputs are decoded from the next state so they are registered yet aligned
      req_ready <= (nxt == S_IDLE);
      pwr_en    <= (nxt == S_PWR_UP) || (nxt == S_START) || (nxt == S_WAIT);
      frm_start <= (nxt == S_START);
      busy      <= !((nxt == S_IDLE) || (nxt == S_ERR));
      upd_done  <= done_pulse;
      err       <= (nxt == S_ERR);
      if (nxt == S_START) begin
        frm_drive    <= drive_of(nxt_phase, nxt_cnt);
        frm_gray_idx <= (nxt_phase == PH_GRAY) ? nxt_cnt[4:0] : '0;
      end
    end
  end

endmodule

// File: tb/tb_epp_update_sched.sv
// Directed bench for epp_update_sched with a 5-cycle frame-engine model and output monitor.
module tb_epp_update_sched;

  localparam int unsigned T_TO = 1023;
  localparam int unsigned H_DN = 255;
  localparam logic [12:0] RST_V = 13'b1_0_0_0_0_0_00_00000;

  logic       glb_clk = 1'b0;
  logic       glb_rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_mode = 2'd0;
  logic       pwr_good = 1'b0;
  logic       eng_done = 1'b0;
  logic       man_done = 1'b0;
  logic       eng_en = 1'b0;
  logic       frm_done;
  logic       req_ready, pwr_en, frm_start, busy, upd_done, err;
  logic [1:0] frm_drive;
  logic [4:0] frm_gray_idx;
`ifdef EPP_SCHED_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  assign frm_done = eng_done | man_done;

  always #5 glb_clk = ~glb_clk;

  epp_update_sched #(.FILL_FRAMES(4)) dut (
    .glb_clk(glb_clk), .glb_rst(glb_rst), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .pwr_en(pwr_en), .pwr_good(pwr_good), .frm_start(frm_start),
    .frm_done(frm_done), .frm_drive(frm_drive), .frm_gray_idx(frm_gray_idx), .busy(busy),
    .upd_done(upd_done), .err(err)
`ifdef EPP_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  // engine model and monitor
  int starts = 0, dones = 0, dn_cyc = 0, cyc = 0, dly = 0;
  logic [1:0] drv_log [512];
  logic [4:0] idx_log [512];
  int         st_cyc  [512];

  initial forever begin
    @(negedge glb_clk);
    cyc++;
    eng_done = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) eng_done = 1'b1;
    end
    if (frm_start === 1'b1) begin
      if (starts < 512) begin
        drv_log[starts] = frm_drive;
        idx_log[starts] = frm_gray_idx;
        st_cyc[starts]  = cyc;
      end
      starts++;
      if (eng_en) dly = 5;
    end
    if (upd_done === 1'b1) dones++;
    if (pwr_en === 1'b0 && busy === 1'b1 && upd_done === 1'b0) dn_cyc++;
  end

  task automatic step(int n);
    repeat (n) @(negedge glb_clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {req_ready, pwr_en, frm_start, busy, upd_done, err, frm_drive, frm_gray_idx};
  endfunction

  task automatic wait_done(string tag, int lim);
    for (int i = 0; i < lim && upd_done !== 1'b1; i++) step(1);
    chk(tag, upd_done, 1);
  endtask

  task automatic wait_starts(string tag, int n, int lim);
    for (int i = 0; i < lim && starts < n; i++) step(1);
    chk(tag, starts, n);
  endtask

  initial begin
    int s0, d0, n0;
    logic [1:0] ed;

    glb_rst = 1'b1; step(3);
    chk("reset_outs", outs(), RST_V);
    glb_rst = 1'b0; step(2);
    chk("idle_outs", outs(), RST_V);
    man_done = 1'b1; step(1); man_done = 1'b0; step(1);
    chk("idle_done_ignored", {outs(), 32'(starts)}, {RST_V, 32'd0});

    // mode 0: clean + gray
    s0 = starts; d0 = dones; n0 = dn_cyc;
    eng_en = 1'b1; req_mode = 2'd0; req_valid = 1'b1; step(1); req_valid = 1'b0;
    chk("m0_accept", {req_ready, pwr_en, busy, frm_start}, 4'b0110);
    step(3);
    chk("m0_pwrup_hold", {pwr_en, frm_start, busy}, 3'b101);
    pwr_good = 1'b1; step(1);
    chk("m0_first_start", {frm_start, frm_drive}, 3'b101);
    step(1);
    chk("m0_start_one_cycle", frm_start, 0);
    wait_done("m0_done", 2000);
    chk("m0_dn_hold", dn_cyc - n0, H_DN);
    chk("m0_pwr_off", pwr_en, 0);
    step(1);
    chk("m0_ready", {req_ready, busy, upd_done}, 3'b100);
    chk("m0_frames", starts - s0, 68);
    chk("m0_dones", dones - d0, 1);
    for (int k = 0; k < 68; k++) begin
      ed = (k < 24) ? 2'b01 : (k < 48) ? 2'b10 : 2'b00;
      chk($sformatf("m0_drv%0d", k), drv_log[s0 + k], ed);
      if (k >= 48) chk($sformatf("m0_idx%0d", k), idx_log[s0 + k], k - 48);
      if (k > 0) chk($sformatf("m0_gap%0d", k), st_cyc[s0 + k] - st_cyc[s0 + k - 1], 6);
    end

    // mode 3: fill black, 4 frames
    s0 = starts; d0 = dones; n0 = dn_cyc;
    req_mode = 2'd3; req_valid = 1'b1; step(1); req_valid = 1'b0;
    wait_done("m3_done", 500);
    chk("m3_dn_hold", dn_cyc - n0, H_DN);
    step(1);
    chk("m3_ready", {req_ready, busy}, 2'b10);
    chk("m3_frames", starts - s0, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("m3_drv%0d", k), drv_log[s0 + k], 2'b01);

    // mode 1: clean only, stray request during WAIT
    s0 = starts; d0 = dones;
    req_mode = 2'd1; req_valid = 1'b1; step(1); req_valid = 1'b0;
    wait_starts("m1_reach10", s0 + 10, 500);
    step(2);
    req_mode = 2'd2; req_valid = 1'b1; step(1); req_valid = 1'b0;
    chk("m1_req_ignored", {req_ready, busy, pwr_en}, 3'b011);
    wait_done("m1_done", 1000);
    step(1);
    chk("m1_frames", starts - s0, 48);
    chk("m1_dones", dones - d0, 1);
    chk("m1_drv23", drv_log[s0 + 23], 2'b01);
    chk("m1_drv24", drv_log[s0 + 24], 2'b10);

    // mode 2: pwr_good drops in gray frame 7
    s0 = starts; d0 = dones;
    req_mode = 2'd2; req_valid = 1'b1; step(1); req_valid = 1'b0;
    wait_starts("m2_reach7", s0 + 8, 500);
    chk("m2_idx7", {drv_log[s0 + 7], idx_log[s0 + 7]}, {2'b00, 5'd7});
    step(2);
    pwr_good = 1'b0; step(1);
    chk("m2_err", {err, pwr_en, req_ready, busy}, 4'b1000);
    req_valid = 1'b1; step(20); req_valid = 1'b0; pwr_good = 1'b1; step(5);
    chk("m2_err_sticky", {err, pwr_en, req_ready, busy}, 4'b1000);
    chk("m2_no_more_start", starts - s0, 8);
    chk("m2_no_done", dones - d0, 0);
    glb_rst = 1'b1; step(1);
    chk("m2_err_reset", outs(), RST_V);
    glb_rst = 1'b0; step(10);

    // power-up timeout
    eng_en = 1'b0; pwr_good = 1'b0; req_mode = 2'd0;
    req_valid = 1'b1; step(1); req_valid = 1'b0;
    chk("to_pwrup", {pwr_en, err}, 2'b10);
    step(T_TO);
    chk("to_last_wait", {pwr_en, err, busy}, 3'b101);
    step(1);
    chk("to_err", {err, pwr_en, req_ready, busy}, 4'b1000);
    step(50);
    chk("to_err_sticky", {err, pwr_en, req_ready, busy}, 4'b1000);
    glb_rst = 1'b1; step(1);
    chk("to_reset", outs(), RST_V);
    glb_rst = 1'b0; step(2);

    // pwr_good rising on the timeout edge wins
    req_valid = 1'b1; step(1); req_valid = 1'b0;
    step(T_TO);
    pwr_good = 1'b1; step(1);
    chk("to_race_start", {frm_start, err}, 2'b10);
    step(2);
    chk("mid_wait", {frm_start, pwr_en, busy}, 3'b011);
    glb_rst = 1'b1; step(1);
    chk("mid_wait_reset", outs(), RST_V);
    glb_rst = 1'b0; step(5);
    chk("post_reset_idle", outs(), RST_V);

`ifdef EPP_SCHED_ABORT_EN
    s0 = starts; d0 = dones; n0 = dn_cyc;
    eng_en = 1'b1; req_mode = 2'd1; req_valid = 1'b1; step(1); req_valid = 1'b0;
    wait_starts("ab_reach10", s0 + 11, 500);
    step(2);
    abort = 1'b1; step(1); abort = 1'b0;
    wait_done("ab_done", 1000);
    chk("ab_dn_hold", dn_cyc - n0, H_DN);
    chk("ab_frames", starts - s0, 11);
    step(1);
    chk("ab_ready", {req_ready, busy, dones - d0 == 1}, 3'b101);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
